// File: rtl/ysyx_23060059_axi_rslave.sv
// AXI4 read-only slave over a 64-bit word memory with a configurable first-beat
// latency and a backdoor preload port. ADDR_BASE is assumed 8-byte aligned.
module ysyx_23060059_axi_rslave #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] axi_araddr,
    input  logic [3:0]  axi_arid,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [63:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic [3:0]  axi_rid,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic        bd_we,
    input  logic [31:0] bd_addr,
    input  logic [63:0] bd_wdata
);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 8);
    localparam logic [3:0]  LAT       = 4'(LATENCY);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_BURST = 2'b10
    } state_e;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return (off < MEM_BYTES);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - ADDR_BASE;
        return AW'(off >> 3);
    endfunction

    logic [63:0] mem [DEPTH];

    state_e      state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [7:0]  beat_q,    beat_d;
    logic [31:0] araddr_q,  araddr_d;
    logic [7:0]  arlen_q,   arlen_d;
    logic [2:0]  arsize_q,  arsize_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [3:0]  rid_q,     rid_d;
    logic [63:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        rlast_q,   rlast_d;
    logic        rvalid_q,  rvalid_d;
    logic        arready_q, arready_d;

    logic        load_s;
    logic [31:0] beat_addr_s;
    logic        illegal_s;
    logic        beat_ok_s;
    logic [63:0] beat_data_s;
    logic [1:0]  beat_resp_s;

    // Backdoor preload; the array has no reset so contents survive reset.
    always_ff @(posedge clock) begin
        if (bd_we && in_range(bd_addr)) begin
            mem[word_idx(bd_addr)] <= bd_wdata;
        end
    end

    // FIXED bursts reuse the start address; INCR steps 8 bytes per beat with 32-bit wrap.
    assign beat_addr_s = (arburst_q == 2'b00) ? araddr_q
                                              : araddr_q + {21'd0, beat_q, 3'b000};
    assign illegal_s   = (arsize_q != 3'b011) || arburst_q[1];
    assign beat_ok_s   = in_range(beat_addr_s);
    assign beat_data_s = (!illegal_s && beat_ok_s) ? mem[word_idx(beat_addr_s)] : 64'd0;
    assign beat_resp_s = illegal_s ? RESP_SLVERR : (beat_ok_s ? RESP_OKAY : RESP_DECERR);

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            beat_q    <= 8'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 8'd0;
            arsize_q  <= 3'd0;
            arburst_q <= 2'd0;
            rid_q     <= 4'd0;
            rdata_q   <= 64'd0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    // Next-state logic; a beat is loaded on the last WAIT cycle and on each non-final handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        rvalid_d  = rvalid_q;
        arready_d = arready_q;
        load_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && arready_q) begin
                    araddr_d  = axi_araddr;
                    arlen_d   = axi_arlen;
                    arsize_d  = axi_arsize;
                    arburst_d = axi_arburst;
                    rid_d     = axi_arid;
                    cnt_d     = LAT;
                    beat_d    = 8'd0;
                    arready_d = 1'b0;
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    load_s  = 1'b1;
                    state_d = S_BURST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                if (rvalid_q && axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            default: begin
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
        rdata_d  = load_s ? beat_data_s : rdata_d;
        rresp_d  = load_s ? beat_resp_s : rresp_d;
        rlast_d  = load_s ? (beat_q == arlen_q) : rlast_d;
        rvalid_d = load_s ? 1'b1 : rvalid_d;
        beat_d   = load_s ? (beat_q + 8'd1) : beat_d;
    end

    assign axi_arready = arready_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;
    assign axi_rvalid  = rvalid_q;

endmodule
